// File: rtl/frame_ram_arbiter.sv
// Three-way round-robin arbiter in front of a single-port synchronous frame RAM.
// Grants are bursty (up to MAX_BURST beats while others wait); reads return rvalid two cycles after acceptance.
module frame_ram_arbiter #(
  parameter int ETH_FRAME_SIZE = 1400,
  parameter int MAX_BURST      = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  req,
  input  logic [2:0]  we,
  input  logic [32:0] addr,
  input  logic [23:0] wdata,
  output logic [2:0]  gnt,
  output logic [2:0]  rvalid,
  output logic [7:0]  rd_data,
  output logic [2:0]  err,
  output logic [10:0] ram_addr,
  output logic [7:0]  ram_data_in,
  output logic        ram_en,
  input  logic [7:0]  ram_data_out
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [11:0] FRAME_LIMIT = 12'(ETH_FRAME_SIZE);
  localparam logic [4:0]  BURST_LAST  = 5'(MAX_BURST - 1);

  state_t      state_q, state_d;
  logic [2:0]  gnt_q, gnt_d;
  logic [1:0]  last_q, last_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [2:0]  rd_pend_q, rd_pend_d;
  logic [2:0]  rvalid_q, rvalid_d;
  logic [2:0]  err_q, err_d;
  logic [10:0] ram_addr_q, ram_addr_d;
  logic [7:0]  ram_data_in_q, ram_data_in_d;
  logic        ram_en_q, ram_en_d;

  logic [1:0]  cur_idx;
  logic [10:0] sel_addr;
  logic [7:0]  sel_wdata;
  logic        sel_we;
  logic        beat;
  logic        others_pending;
  logic        in_range;

  // Round-robin pick: first requesting index after last, wrapping 2 -> 0.
  function automatic logic [1:0] rr_pick(input logic [2:0] r, input logic [1:0] last);
    logic [1:0] pick;
    case (last)
      2'd0: begin
        if (r[1]) pick = 2'd1;
        else if (r[2]) pick = 2'd2;
        else pick = 2'd0;
      end
      2'd1: begin
        if (r[2]) pick = 2'd2;
        else if (r[0]) pick = 2'd0;
        else pick = 2'd1;
      end
      default: begin
        if (r[0]) pick = 2'd0;
        else if (r[1]) pick = 2'd1;
        else pick = 2'd2;
      end
    endcase
    return pick;
  endfunction

  function automatic logic [2:0] idx_to_onehot(input logic [1:0] idx);
    logic [2:0] oh;
    case (idx)
      2'd0:    oh = 3'b001;
      2'd1:    oh = 3'b010;
      2'd2:    oh = 3'b100;
      default: oh = 3'b000;
    endcase
    return oh;
  endfunction

  // Route the granted requester's address, data and direction.
  always_comb begin
    cur_idx   = 2'd0;
    sel_addr  = addr[10:0];
    sel_wdata = wdata[7:0];
    sel_we    = we[0];
    case (gnt_q)
      3'b010: begin
        cur_idx   = 2'd1;
        sel_addr  = addr[21:11];
        sel_wdata = wdata[15:8];
        sel_we    = we[1];
      end
      3'b100: begin
        cur_idx   = 2'd2;
        sel_addr  = addr[32:22];
        sel_wdata = wdata[23:16];
        sel_we    = we[2];
      end
      default: begin
        cur_idx   = 2'd0;
        sel_addr  = addr[10:0];
        sel_wdata = wdata[7:0];
        sel_we    = we[0];
      end
    endcase
  end

  assign beat           = (state_q == GRANT) && ((gnt_q & req) != 3'b000);
  assign others_pending = ((req & ~gnt_q) != 3'b000);
  assign in_range       = ({1'b0, sel_addr} < FRAME_LIMIT);

  // Next-state, grant, burst counter and RAM command logic.
  always_comb begin
    state_d       = state_q;
    gnt_d         = gnt_q;
    last_d        = last_q;
    cnt_d         = cnt_q;
    rd_pend_d     = 3'b000;
    rvalid_d      = rd_pend_q;
    err_d         = 3'b000;
    ram_en_d      = 1'b0;
    ram_addr_d    = ram_addr_q;
    ram_data_in_d = ram_data_in_q;
    case (state_q)
      IDLE: begin
        if (req != 3'b000) begin
          gnt_d   = idx_to_onehot(rr_pick(req, last_q));
          state_d = GRANT;
          cnt_d   = 5'd0;
        end else begin
          gnt_d   = 3'b000;
        end
      end
      GRANT: begin
        if (!beat) begin
          gnt_d   = 3'b000;
          state_d = IDLE;
          last_d  = cur_idx;
          cnt_d   = 5'd0;
        end else begin
          // Out-of-range beats hold the RAM port idle but still count toward the burst.
          if (in_range) begin
            ram_addr_d    = sel_addr;
            ram_data_in_d = sel_wdata;
            ram_en_d      = sel_we;
            rd_pend_d     = sel_we ? 3'b000 : gnt_q;
          end else begin
            err_d         = gnt_q;
          end
          if (cnt_q == BURST_LAST) begin
            cnt_d = 5'd0;
            if (others_pending) begin
              gnt_d   = 3'b000;
              state_d = IDLE;
              last_d  = cur_idx;
            end else begin
              gnt_d   = gnt_q;
            end
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 3'b000;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      gnt_q         <= 3'b000;
      last_q        <= 2'd2;
      cnt_q         <= 5'd0;
      rd_pend_q     <= 3'b000;
      rvalid_q      <= 3'b000;
      err_q         <= 3'b000;
      ram_addr_q    <= 11'd0;
      ram_data_in_q <= 8'd0;
      ram_en_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      gnt_q         <= gnt_d;
      last_q        <= last_d;
      cnt_q         <= cnt_d;
      rd_pend_q     <= rd_pend_d;
      rvalid_q      <= rvalid_d;
      err_q         <= err_d;
      ram_addr_q    <= ram_addr_d;
      ram_data_in_q <= ram_data_in_d;
      ram_en_q      <= ram_en_d;
    end
  end

  assign gnt         = gnt_q;
  assign rvalid      = rvalid_q;
  assign err         = err_q;
  assign ram_addr    = ram_addr_q;
  assign ram_data_in = ram_data_in_q;
  assign ram_en      = ram_en_q;
  assign rd_data     = ram_data_out;

endmodule

// File: tb/tb_frame_ram_arbiter.sv
// Directed bench for frame_ram_arbiter with a behavioural 1-cycle-latency frame RAM.
module tb_frame_ram_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  req;
  logic [2:0]  we;
  logic [32:0] addr;
  logic [23:0] wdata;
  logic [2:0]  gnt;
  logic [2:0]  rvalid;
  logic [7:0]  rd_data;
  logic [2:0]  err;
  logic [10:0] ram_addr;
  logic [7:0]  ram_data_in;
  logic        ram_en;
  logic [7:0]  ram_data_out;

  logic [7:0]  mem [0:2047];

  int n_checks = 0;
  int n_fail   = 0;

  frame_ram_arbiter #(.ETH_FRAME_SIZE(1400), .MAX_BURST(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .req          (req),
    .we           (we),
    .addr         (addr),
    .wdata        (wdata),
    .gnt          (gnt),
    .rvalid       (rvalid),
    .rd_data      (rd_data),
    .err          (err),
    .ram_addr     (ram_addr),
    .ram_data_in  (ram_data_in),
    .ram_en       (ram_en),
    .ram_data_out (ram_data_out)
  );

  always #5 clk = ~clk;

  // Synchronous frame RAM, read-before-write.
  always @(posedge clk) begin
    ram_data_out <= mem[ram_addr];
    if (ram_en) mem[ram_addr] <= ram_data_in;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    check_eq({tag, "_gnt"}, {29'd0, gnt}, 32'd0);
    check_eq({tag, "_rvalid"}, {29'd0, rvalid}, 32'd0);
    check_eq({tag, "_err"}, {29'd0, err}, 32'd0);
    check_eq({tag, "_ram_en"}, {31'd0, ram_en}, 32'd0);
    check_eq({tag, "_ram_addr"}, {21'd0, ram_addr}, 32'd0);
    check_eq({tag, "_ram_din"}, {24'd0, ram_data_in}, 32'd0);
  endtask

  initial begin
    logic [2:0] exp_gnt;
    int beats;

    for (int i = 0; i < 2048; i++) mem[i] = 8'h00;
    mem[100] = 8'h3C;
    reset = 1'b1;
    req   = 3'b000;
    we    = 3'b000;
    addr  = 33'd0;
    wdata = 24'd0;

    // Reset state
    step();
    step();
    check_quiet("reset");
    reset = 1'b0;
    step();

    // Single writer, requester 0, addr 5, 0xA5; non-granted lanes carry junk
    req   = 3'b001;
    we    = 3'b011;
    addr  = {11'd0, 11'd2000, 11'd5};
    wdata = {8'h00, 8'hEE, 8'hA5};
    step();
    check_eq("wr_gnt", {29'd0, gnt}, 32'h1);
    check_eq("wr_en_pre", {31'd0, ram_en}, 32'h0);
    for (int b = 0; b < 2; b++) begin
      step();
      check_eq("wr_gnt_hold", {29'd0, gnt}, 32'h1);
      check_eq("wr_addr", {21'd0, ram_addr}, 32'd5);
      check_eq("wr_din", {24'd0, ram_data_in}, 32'hA5);
      check_eq("wr_en", {31'd0, ram_en}, 32'h1);
      check_eq("wr_err", {29'd0, err}, 32'h0);
    end
    req = 3'b000;
    step();
    check_eq("wr_release", {29'd0, gnt}, 32'h0);
    check_eq("wr_en_off", {31'd0, ram_en}, 32'h0);
    step();
    check_eq("wr_mem", {24'd0, mem[5]}, 32'hA5);

    // Read latency, requester 1 reads addr 100; release before rvalid arrives
    req  = 3'b010;
    we   = 3'b000;
    addr = {11'd0, 11'd100, 11'd0};
    step();
    check_eq("rd_gnt", {29'd0, gnt}, 32'h2);
    step();
    check_eq("rd_addr", {21'd0, ram_addr}, 32'd100);
    check_eq("rd_en", {31'd0, ram_en}, 32'h0);
    check_eq("rd_rvalid_early", {29'd0, rvalid}, 32'h0);
    req = 3'b000;
    step();
    check_eq("rd_rvalid", {29'd0, rvalid}, 32'h2);
    check_eq("rd_data", {24'd0, rd_data}, 32'h3C);
    check_eq("rd_released", {29'd0, gnt}, 32'h0);
    step();
    check_eq("rd_rvalid_off", {29'd0, rvalid}, 32'h0);

    // Out-of-range write by requester 0, then an in-range one
    req   = 3'b001;
    we    = 3'b001;
    addr  = {11'd0, 11'd0, 11'd1400};
    wdata = {8'h00, 8'h00, 8'h11};
    step();
    check_eq("oor_gnt", {29'd0, gnt}, 32'h1);
    step();
    check_eq("oor_err", {29'd0, err}, 32'h1);
    check_eq("oor_en", {31'd0, ram_en}, 32'h0);
    check_eq("oor_addr_held", {21'd0, ram_addr}, 32'd100);
    addr  = {11'd0, 11'd0, 11'd0};
    wdata = {8'h00, 8'h00, 8'h77};
    step();
    check_eq("oor_err_off", {29'd0, err}, 32'h0);
    check_eq("oor_rvalid", {29'd0, rvalid}, 32'h0);
    check_eq("ok_en", {31'd0, ram_en}, 32'h1);
    check_eq("ok_addr", {21'd0, ram_addr}, 32'd0);
    check_eq("ok_din", {24'd0, ram_data_in}, 32'h77);
    req = 3'b000;
    step();
    check_eq("oor_release", {29'd0, gnt}, 32'h0);

    // Round robin with all three requesting: 16-beat grants, one idle cycle between
    reset = 1'b1;
    step();
    reset = 1'b0;
    req   = 3'b111;
    we    = 3'b000;
    addr  = {11'd30, 11'd20, 11'd10};
    for (int n = 0; n < 70; n++) begin
      step();
      exp_gnt = ((n % 17) == 16) ? 3'b000 : (3'b001 << ((n / 17) % 3));
      check_eq($sformatf("rr_gnt_%0d", n), {29'd0, gnt}, {29'd0, exp_gnt});
    end
    req = 3'b000;
    step();
    step();
    check_eq("rr_idle", {29'd0, gnt}, 32'h0);

    // Sole requester past the burst limit: continuous grant, 39 beats
    req   = 3'b100;
    we    = 3'b100;
    addr  = {11'd200, 11'd0, 11'd0};
    wdata = {8'h5A, 8'h00, 8'h00};
    beats = 0;
    for (int n = 0; n < 40; n++) begin
      step();
      check_eq($sformatf("solo_gnt_%0d", n), {29'd0, gnt}, 32'h4);
      if (ram_en) beats++;
    end
    check_eq("solo_beats", beats, 32'd39);
    req = 3'b000;
    step();
    check_eq("solo_release", {29'd0, gnt}, 32'h0);
    step();

    // Reset one cycle after a read acceptance
    req  = 3'b001;
    we   = 3'b000;
    addr = {11'd0, 11'd0, 11'd100};
    step();
    check_eq("rst_rd_gnt", {29'd0, gnt}, 32'h1);
    step();
    check_eq("rst_rd_addr", {21'd0, ram_addr}, 32'd100);
    reset = 1'b1;
    req   = 3'b000;
    step();
    check_quiet("rst_mid");
    reset = 1'b0;
    req   = 3'b111;
    step();
    check_eq("rst_first_gnt", {29'd0, gnt}, 32'h1);
    check_eq("rst_no_rvalid", {29'd0, rvalid}, 32'h0);
    step();
    check_eq("rst_no_rvalid2", {29'd0, rvalid}, 32'h0);
    check_eq("rst_no_err", {29'd0, err}, 32'h0);
    req = 3'b000;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
